// File: rtl/led_manager_pkg.sv
// rtl/led_manager_pkg.sv - shared constants for the LED manager
// Purpose: LED bit positions for both display views and the default
//          activity-indicator hold time.
// Ports:   none (package).
package led_manager_pkg;

    localparam int ACT_TIMEOUT_DEFAULT = 1024;

    // Status view field positions
    localparam int LED_CM_ERR_LSB   = 12;
    localparam int LED_UART_ERR_LSB = 10;
    localparam int LED_VGA_ACT      = 9;
    localparam int LED_UART_ACT     = 8;

    // Shared by both views
    localparam int LED_CFG_LSB      = 0;

    // Debug view field position
    localparam int LED_DBG_BYTE_LSB = 8;

endpackage

// File: rtl/activity_detector.sv
// rtl/activity_detector.sv - synchronise, edge-detect and hold an activity flag
// Purpose: samples a foreign signal (e.g. a clock) as data through a 2-flop
//          synchroniser, detects either edge, and holds an activity flag for
//          TIMEOUT-1 cycles after the last edge.
// Ports:   clk, rst (async active-high), sig_in (monitored signal),
//          active_next (activity flag as it will be after this edge).
module activity_detector
    import led_manager_pkg::*;
#(
    parameter int TIMEOUT = ACT_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic active_next
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             edge_seen;

    always_comb begin
        sync1_d   = sig_in;
        sync2_d   = sync1_q;
        last_d    = sync2_q;
        edge_seen = sync2_q ^ last_q;
        cnt_d     = cnt_q;
        if (edge_seen) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // The top registers the LEDs from next-state, so expose the flag
        // that the counter will carry after this edge.
        active_next = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/led_manager.sv
// rtl/led_manager.sv - board LED status / debug display
// Purpose: keeps sticky CM and UART error flags (cleared on a configuration
//          change), the last received UART byte, and VGA/UART clock activity
//          flags, and muxes them onto 16 registered LEDs.
// Ports:   clk, rst (async active-high), UART_data_debug_switch (1 = debug),
//          clkVGA/clkUART (monitored as data), UART_data/_valid,
//          CM_errors/_valid, UART_errors/_valid, config_notification,
//          leds (registered output).
module led_manager
    import led_manager_pkg::*;
#(
    parameter int ACT_TIMEOUT = ACT_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        UART_data_debug_switch,
    input  logic        clkVGA,
    input  logic        clkUART,
    input  logic [7:0]  UART_data,
    input  logic        UART_data_valid,
    input  logic [3:0]  CM_errors,
    input  logic        CM_errors_valid,
    input  logic [1:0]  UART_errors,
    input  logic        UART_errors_valid,
    input  logic [7:0]  config_notification,
    output logic [15:0] leds
);

    logic [3:0]  cm_err_q,    cm_err_d;
    logic [1:0]  uart_err_q,  uart_err_d;
    logic [7:0]  last_byte_q, last_byte_d;
    logic [7:0]  cfg_q,       cfg_d;
    logic [15:0] leds_q,      leds_d;
    logic        cfg_changed;
    logic        vga_active_next;
    logic        uart_active_next;

    activity_detector #(.TIMEOUT(ACT_TIMEOUT)) u_vga_activity (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (clkVGA),
        .active_next (vga_active_next)
    );

    activity_detector #(.TIMEOUT(ACT_TIMEOUT)) u_uart_activity (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (clkUART),
        .active_next (uart_active_next)
    );

    always_comb begin
        cfg_changed = (config_notification != cfg_q);
        cfg_d       = config_notification;

        // Clear first, then OR, so errors arriving with a config change survive.
        cm_err_d   = cfg_changed ? 4'b0000 : cm_err_q;
        uart_err_d = cfg_changed ? 2'b00   : uart_err_q;
        if (CM_errors_valid) begin
            cm_err_d = cm_err_d | CM_errors;
        end
        if (UART_errors_valid) begin
            uart_err_d = uart_err_d | UART_errors;
        end

        last_byte_d = UART_data_valid ? UART_data : last_byte_q;

        leds_d = 16'h0000;
        leds_d[LED_CFG_LSB +: 8] = cfg_d;
        if (UART_data_debug_switch) begin
            leds_d[LED_DBG_BYTE_LSB +: 8] = last_byte_d;
        end else begin
            leds_d[LED_CM_ERR_LSB +: 4]   = cm_err_d;
            leds_d[LED_UART_ERR_LSB +: 2] = uart_err_d;
            leds_d[LED_VGA_ACT]           = vga_active_next;
            leds_d[LED_UART_ACT]          = uart_active_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cm_err_q    <= '0;
            uart_err_q  <= '0;
            last_byte_q <= '0;
            cfg_q       <= '0;
            leds_q      <= '0;
        end else begin
            cm_err_q    <= cm_err_d;
            uart_err_q  <= uart_err_d;
            last_byte_q <= last_byte_d;
            cfg_q       <= cfg_d;
            leds_q      <= leds_d;
        end
    end

    assign leds = leds_q;

endmodule

// File: tb/tb_led_manager.sv
// tb/tb_led_manager.sv - scoreboard bench for led_manager
module tb_led_manager;

    localparam int T = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        sw;
    logic        vga_in, uart_in;
    logic [7:0]  data;
    logic        data_v;
    logic [3:0]  cm;
    logic        cm_v;
    logic [1:0]  ue;
    logic        ue_v;
    logic [7:0]  cfg;
    logic [15:0] leds;

    always #5 clk = ~clk;

    led_manager #(.ACT_TIMEOUT(T)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .UART_data_debug_switch (sw),
        .clkVGA                 (vga_in),
        .clkUART                (uart_in),
        .UART_data              (data),
        .UART_data_valid        (data_v),
        .CM_errors              (cm),
        .CM_errors_valid        (cm_v),
        .UART_errors            (ue),
        .UART_errors_valid      (ue_v),
        .config_notification    (cfg),
        .leds                   (leds)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    // Reference model state
    logic [3:0] m_cm;
    logic [1:0] m_ue;
    logic [7:0] m_lb;
    logic [7:0] m_cfg;
    bit         hv[$];
    bit         hu[$];
    int         n_edge;
    int         last_v;
    int         last_u;

    task automatic model_reset();
        m_cm = '0; m_ue = '0; m_lb = '0; m_cfg = '0;
        hv = '{1'b0, 1'b0, 1'b0};
        hu = '{1'b0, 1'b0, 1'b0};
        last_v = -1000000;
        last_u = -1000000;
        n_edge = 0;
    endtask

    // The DUT sees a signal two synchroniser stages late; an edge between
    // the samples taken 2 and 3 edges ago reloads the hold window, which then
    // stays lit for T-1 edges in total.
    task automatic model_step();
        bit act_v, act_u;
        hv.push_back(vga_in);
        hu.push_back(uart_in);
        if (hv.size() > 4) void'(hv.pop_front());
        if (hu.size() > 4) void'(hu.pop_front());
        if (hv[1] != hv[0]) last_v = n_edge;
        if (hu[1] != hu[0]) last_u = n_edge;
        act_v = (n_edge - last_v) <= (T - 2);
        act_u = (n_edge - last_u) <= (T - 2);

        if (cfg != m_cfg) begin
            m_cm = '0;
            m_ue = '0;
        end
        if (cm_v) m_cm = m_cm | cm;
        if (ue_v) m_ue = m_ue | ue;
        m_cfg = cfg;
        if (data_v) m_lb = data;

        if (sw) exp_q.push_back({m_lb, m_cfg});
        else    exp_q.push_back({m_cm, m_ue, act_v, act_u, m_cfg});
        n_edge++;
    endtask

    // Called at a falling edge with inputs already set; returns at the next.
    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_valids();
        data_v = 1'b0; cm_v = 1'b0; ue_v = 1'b0;
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if (leds !== 16'h0000) begin
            n_fail++;
            $display("FAIL %s: leds=%h expected=0000", name, leds);
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        #0 check_zero("reset_hold");
        rst = 1'b0;
    endtask

    // Monitor: one registered output per edge, checked 1 time unit later.
    always @(posedge clk) begin
        logic [15:0] e;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (leds !== e) begin
                n_fail++;
                $display("FAIL leds @%0t: actual=%h expected=%h", $time, leds, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int rate_v, rate_u;
        rst = 1'b1; sw = 1'b0; vga_in = 1'b0; uart_in = 1'b0;
        data = '0; data_v = 1'b0; cm = '0; cm_v = 1'b0;
        ue = '0; ue_v = 1'b0; cfg = '0;
        model_reset();
        #1;
        check_zero("reset_before_clk");
        @(negedge clk);
        @(negedge clk);
        check_zero("reset_hold_init");
        rst = 1'b0;

        // CM error accumulation under config 0x81
        cfg = 8'h81; tick(); tick();
        cm = 4'b1101; cm_v = 1'b1; tick();
        cm = 4'b0010; tick();
        cm_v = 1'b0; tick();

        // UART error, then config change clears both
        ue = 2'b01; ue_v = 1'b1; tick();
        ue_v = 1'b0; tick();
        cfg = 8'h8D; tick(); tick();

        // Debug view last-byte, switch back keeps error flags
        cm = 4'b1010; cm_v = 1'b1; ue = 2'b10; ue_v = 1'b1; tick();
        clear_valids();
        sw = 1'b1; data = 8'hDD; data_v = 1'b1; tick();
        data = 8'hD1; tick();
        data_v = 1'b0; data = 8'h00; tick(); tick();
        sw = 1'b0; tick(); tick();

        // Config change and CM error in the same cycle
        cfg = 8'h42; cm = 4'b0100; cm_v = 1'b1; tick();
        cm_v = 1'b0; tick();

        // VGA activity: toggle every 4 clk, then static while UART toggles
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) vga_in = ~vga_in;
            tick();
        end
        for (int i = 0; i < T + 3; i++) begin
            if (i % 3 == 0) uart_in = ~uart_in;
            tick();
        end
        for (int i = 0; i < T + 3; i++) tick();

        // Mid-run asynchronous reset with live state
        cm = 4'b1111; cm_v = 1'b1; vga_in = ~vga_in; tick();
        cm_v = 1'b0;
        do_reset();
        tick(); tick();

        // Randomised traffic
        rate_v = 0; rate_u = 0;
        for (int i = 0; i < 900; i++) begin
            if (i % 100 == 0) begin
                rate_v = (($urandom % 3) == 0) ? 0 : (($urandom % 2) ? 3 : 30);
                rate_u = (($urandom % 3) == 0) ? 0 : (($urandom % 2) ? 3 : 30);
            end
            if ($urandom_range(0, 99) < rate_v) vga_in = ~vga_in;
            if ($urandom_range(0, 99) < rate_u) uart_in = ~uart_in;
            data   = 8'($urandom);
            data_v = ($urandom % 4) == 0;
            cm     = 4'($urandom);
            cm_v   = ($urandom % 8) == 0;
            ue     = 2'($urandom);
            ue_v   = ($urandom % 8) == 0;
            if (($urandom % 20) == 0) cfg = 8'($urandom);
            if (($urandom % 50) == 0) sw = ~sw;
            tick();
        end
        clear_valids();
        tick();

        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected outputs left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
